// File: rtl/cla_pkg.sv
// Shared widths for the two-stage 64-bit carry-lookahead adder.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Ports: none; DATA_W operand width, HALF_W per-stage width,
//        GROUP_W lookahead group width, NUM_GROUPS groups per half.
package cla_pkg;
  localparam int DATA_W     = 64;
  localparam int HALF_W     = 32;
  localparam int GROUP_W    = 4;
  localparam int NUM_GROUPS = HALF_W / GROUP_W;
  localparam int SUM_W      = DATA_W + 1;
endpackage

// File: rtl/cla_2stage_64_if.sv
// Operand/result bundle for the two-stage 64-bit adder.
// Latency: n/a (wires only).
// Backpressure: none; the adder accepts a new pair every cycle.
// Signals: in_a, in_b (64b operands), out_sum (65b {carry, sum}).
interface cla_2stage_64_if;
  import cla_pkg::*;

  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [SUM_W-1:0]  out_sum;

  // master drives operands and consumes the sum; slave is the adder
  modport master (output in_a, output in_b, input  out_sum);
  modport slave  (input  in_a, input  in_b, output out_sum);
endinterface

// File: rtl/cla_32.sv
// 32-bit two-level carry-lookahead adder (4-bit groups, lookahead across groups).
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b (32b operands), cin -> sum (32b), cout.
module cla_32
  import cla_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] sum,
  output logic              cout
);

  logic [HALF_W-1:0]     g;
  logic [HALF_W-1:0]     p;
  logic [HALF_W-1:0]     c;        // carry into each bit
  logic [NUM_GROUPS-1:0] grp_g;
  logic [NUM_GROUPS-1:0] grp_p;
  logic [NUM_GROUPS:0]   gen_ext;  // {group generates, cin}: index 0 is cin
  logic [NUM_GROUPS:0]   grp_c;    // carry into each group, [NUM_GROUPS] is cout

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate; the 4-bit span is the only ripple-shaped term.
  always_comb begin : group_gp
    grp_g = '0;
    grp_p = '0;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      grp_p[k] = 1'b1;
      for (int i = 0; i < GROUP_W; i++) begin
        grp_g[k] = g[k*GROUP_W+i] | (p[k*GROUP_W+i] & grp_g[k]);
        grp_p[k] = grp_p[k] & p[k*GROUP_W+i];
      end
    end
  end

  assign gen_ext = {grp_g, cin};

  // Second level: each group carry is a flat sum of products,
  // c[k+1] = OR_j ( gen_ext[j] & P[j..k] ), so no carry passes group to group.
  always_comb begin : group_carry
    logic term;
    term  = 1'b0;
    grp_c = '0;
    grp_c[0] = cin;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      for (int j = 0; j <= k + 1; j++) begin
        term = gen_ext[j];
        for (int m = j; m <= k; m++) begin
          term = term & grp_p[m];
        end
        grp_c[k+1] = grp_c[k+1] | term;
      end
    end
  end

  // Bit carries inside a group start from the looked-ahead group carry.
  always_comb begin : bit_carry
    logic carry;
    carry = 1'b0;
    c     = '0;
    for (int k = 0; k < NUM_GROUPS; k++) begin
      carry = grp_c[k];
      for (int i = 0; i < GROUP_W; i++) begin
        c[k*GROUP_W+i] = carry;
        carry = g[k*GROUP_W+i] | (p[k*GROUP_W+i] & carry);
      end
    end
  end

  assign sum  = p ^ c;
  assign cout = grp_c[NUM_GROUPS];

endmodule

// File: rtl/cla_2stage_64.sv
// 64-bit unsigned adder, low half in stage 1, high half plus carry in stage 2.
// Latency: 2 rising edges from operand sample to out_sum; 1 add per cycle.
// Backpressure: none; a new operand pair is taken every cycle.
// Ports: clock, reset (async, active-low), bus.slave (in_a, in_b -> out_sum).
module cla_2stage_64
  import cla_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  cla_2stage_64_if.slave   bus
);

  logic [HALF_W-1:0] lo_sum;
  logic              lo_cout;
  logic [HALF_W-1:0] hi_sum;
  logic              hi_cout;

  logic [HALF_W-1:0] s1_lo;
  logic              s1_c32;
  logic [HALF_W-1:0] s1_a_hi;
  logic [HALF_W-1:0] s1_b_hi;
  logic [SUM_W-1:0]  out_q;

  cla_32 u_cla_lo (
    .a    (bus.in_a[HALF_W-1:0]),
    .b    (bus.in_b[HALF_W-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  // Upper half works on registered operands so the bit-31 carry crosses
  // the stage boundary through s1_c32.
  cla_32 u_cla_hi (
    .a    (s1_a_hi),
    .b    (s1_b_hi),
    .cin  (s1_c32),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_lo   <= '0;
      s1_c32  <= 1'b0;
      s1_a_hi <= '0;
      s1_b_hi <= '0;
      out_q   <= '0;
    end else begin
      s1_lo   <= lo_sum;
      s1_c32  <= lo_cout;
      s1_a_hi <= bus.in_a[DATA_W-1:HALF_W];
      s1_b_hi <= bus.in_b[DATA_W-1:HALF_W];
      out_q   <= {hi_cout, hi_sum, s1_lo};
    end
  end

  assign bus.out_sum = out_q;

endmodule

// File: tb/tb_cla_2stage_64.sv
// Bench for cla_2stage_64: vector table, streaming, async reset, random pairs.
// Latency: expects each result 2 edges after its operands are sampled.
// Backpressure: none; operands driven on falling edges, outputs sampled there.
module tb_cla_2stage_64;
  import cla_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  cla_2stage_64_if bus ();

  cla_2stage_64 dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string             name;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SUM_W-1:0]  exp;
  } vec_t;

  typedef struct {
    string            name;
    logic [SUM_W-1:0] exp;
    int               due;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[10];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [SUM_W-1:0] act,
                       input logic [SUM_W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out_sum=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and retire every result now due.
  task automatic tick();
    sb_t e;
    @(negedge clock);
    cyc++;
    while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
      e = sb_q.pop_front();
      check(e.name, bus.out_sum, e.exp);
    end
  endtask

  task automatic push_exp(input string name, input logic [SUM_W-1:0] exp, input int lat);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    e.due  = cyc + lat;
    sb_q.push_back(e);
  endtask

  task automatic drive(input string name, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [SUM_W-1:0] exp);
    bus.in_a = a;
    bus.in_b = b;
    push_exp(name, exp, 2);
  endtask

  task automatic step(input string name, input logic [DATA_W-1:0] a,
                      input logic [DATA_W-1:0] b, input logic [SUM_W-1:0] exp);
    tick();
    drive(name, a, b, exp);
  endtask

  function automatic logic [SUM_W-1:0] ref_add(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  initial begin
    logic [DATA_W-1:0] ra;
    logic [DATA_W-1:0] rb;

    vecs[0] = '{"zero",        64'h0,                   64'h0,                   65'h0_0000_0000_0000_0000};
    vecs[1] = '{"one_plus_max",64'h1,                   64'hFFFF_FFFF_FFFF_FFFF, 65'h1_0000_0000_0000_0000};
    vecs[2] = '{"mid_carry",   64'h0000_0000_FFFF_FFFF, 64'h1,                   65'h0_0000_0001_0000_0000};
    vecs[3] = '{"max_max",     64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE};
    vecs[4] = '{"msb_msb",     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 65'h1_0000_0000_0000_0000};
    vecs[5] = '{"long_prop",   64'h7FFF_FFFF_FFFF_FFFF, 64'h1,                   65'h0_8000_0000_0000_0000};
    vecs[6] = '{"mixed",       64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 65'h0_2222_2222_2222_2211};
    vecs[7] = '{"alt_bits",    64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 65'h0_FFFF_FFFF_FFFF_FFFF};
    vecs[8] = '{"group_edge",  64'h0000_0000_0000_000F, 64'h1,                   65'h0_0000_0000_0000_0010};
    vecs[9] = '{"hi_carry_in", 64'h0000_0001_8000_0000, 64'h0000_0002_8000_0000, 65'h0_0000_0004_0000_0000};

    // Reset held with live operands and a running clock: output stays 0.
    reset    = 1'b0;
    bus.in_a = 64'hDEAD_BEEF_CAFE_F00D;
    bus.in_b = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("reset_hold", bus.out_sum, '0);
    end

    // Release on a falling edge; the next rising edge samples the first pair.
    tick();
    reset = 1'b1;
    drive("first_after_reset", 64'h5, 64'h7, 65'hC);

    // Table applied back-to-back: one result per cycle, in order.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].exp);
    end

    // Mid carry isolated between zero adds: it must show up exactly 2 edges
    // after sampling, with zero results on both neighbouring cycles.
    step("pre_zero",  64'h0, 64'h0, '0);
    step("mid_carry_iso", 64'h0000_0000_FFFF_FFFF, 64'h1, 65'h0_0000_0001_0000_0000);
    step("post_zero", 64'h0, 64'h0, '0);

    // Three distinct pairs streamed on consecutive edges.
    step("stream0", 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 65'h3);
    step("stream1", 64'hFFFF_FFFF_0000_0000, 64'h0000_0001_0000_0000, 65'h1_0000_0000_0000_0000);
    step("stream2", 64'h0123_4567_FFFF_FFFF, 64'h0000_0000_0000_0002, 65'h0_0123_4568_0000_0001);

    // Async reset mid-stream: in-flight results discarded, output clears
    // without waiting for a clock edge.
    step("inflight0", 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 65'h1_0000_0000_0000_0001);
    step("inflight1", 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 65'h0_3333_3333_3333_3333);
    #2;
    check("pre_async_reset", bus.out_sum, 65'h0_0000_0000_0000_0000 | ref_add(64'h0123_4567_FFFF_FFFF, 64'h2));
    reset = 1'b0;
    #1;
    check("async_reset", bus.out_sum, '0);
    sb_q.delete();
    tick();
    check("reset_low_edge", bus.out_sum, '0);
    reset = 1'b1;
    push_exp("refill_zero", '0, 1);
    drive("refill_first", 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001, 65'h1_0000_0000_0000_0000);
    step("refill_second", 64'h42, 64'h58, 65'h9A);

    // Random full-width pairs, each held for 3 clock periods.
    for (int i = 0; i < 10000; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      step("random", ra, rb, ref_add(ra, rb));
      tick();
      tick();
    end

    for (int i = 0; i < 3; i++) tick();
    if (sb_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results pending, expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
